// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable clock divider with shadowed divisors
// Each channel emits a near-50% divided clock and a one-cycle wrap tick.
module clkdiv_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 12_000_000
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                div_load,
    input  logic [2:0]          div_ch,
    input  logic [WIDTH-1:0]    div_val,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] act;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] meff;
        logic [WIDTH-1:0] low_len;
        logic             load_hit;
        logic             out_q;
        logic             tk_q;

        // A zero divisor behaves as divide-by-one; the low phase takes the odd cycle.
        assign meff     = (act == '0) ? WIDTH'(1) : act;
        assign low_len  = meff - (meff >> 1);
        assign load_hit = div_load && (div_ch == 3'(c));

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                shadow <= RESET_DIV;
            end else if (load_hit) begin
                shadow <= div_val;
            end
        end

        // act only ever follows shadow at a period boundary, disable or sync.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                act   <= RESET_DIV;
                cnt   <= '0;
                out_q <= 1'b0;
                tk_q  <= 1'b0;
            end else if (!en[c] || sync) begin
                act   <= shadow;
                cnt   <= '0;
                out_q <= 1'b0;
                tk_q  <= 1'b0;
            end else if (cnt == meff - WIDTH'(1)) begin
                act   <= shadow;
                cnt   <= '0;
                out_q <= 1'b0;
                tk_q  <= 1'b1;
            end else begin
                cnt  <= cnt + WIDTH'(1);
                tk_q <= 1'b0;
                if (cnt + WIDTH'(1) == low_len) begin
                    out_q <= 1'b1;
                end
            end
        end

        assign clk_out[c] = out_q;
        assign tick[c]    = tk_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - directed self-checking bench for clkdiv_multi
module tb_clkdiv_multi;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 24;

    logic                clk_in = 1'b0;
    logic                clk_run = 1'b1;
    logic                rst_n;
    logic [CHANNELS-1:0] en;
    logic                sync;
    logic                div_load;
    logic [2:0]          div_ch;
    logic [WIDTH-1:0]    div_val;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    int n_cmp = 0;
    int n_bad = 0;

    clkdiv_multi #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .div_load(div_load),
        .div_ch  (div_ch),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always begin
        #5;
        if (clk_run) clk_in = ~clk_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge; strobes are single-cycle so they drop after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
        div_load = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic load(input logic [2:0] ch, input logic [WIDTH-1:0] val);
        div_load = 1'b1;
        div_ch   = ch;
        div_val  = val;
    endtask

    // so/st hold the expected clk_out/tick per edge, first edge first.
    task automatic run_chk(input string tag, input int lo, input int hi,
                           input string so, input string st);
        for (int i = 0; i < so.len(); i++) begin
            step();
            for (int c = lo; c <= hi; c++) begin
                check_eq($sformatf("%s_out%0d_e%0d", tag, c, i), 32'(clk_out[c]), 32'(so[i] == "1"));
                check_eq($sformatf("%s_tick%0d_e%0d", tag, c, i), 32'(tick[c]), 32'(st[i] == "1"));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = '0;
        sync     = 1'b0;
        div_load = 1'b0;
        div_ch   = '0;
        div_val  = '0;
        repeat (3) step();
        check_eq("reset_clk_out", 32'(clk_out), 32'd0);
        check_eq("reset_tick", 32'(tick), 32'd0);

        // Default divide-by-4 on both channels.
        rst_n = 1'b1;
        en    = 2'b11;
        run_chk("div4", 0, 1, "01100110", "00010001");

        // Load 5 on ch0 mid-run: the current 4-period completes first.
        load(3'd0, 24'd5);
        run_chk("to5", 0, 0, "01100011000110", "00010000100001");

        // Load 7 on ch1 on the edge it wraps: one more 4-period, then 7.
        step();
        load(3'd1, 24'd7);
        run_chk("wrap7", 1, 1, "001100001110", "100010000001");

        // M = 0 then M = 1 on ch0, then disable.
        en = 2'b10;
        load(3'd0, 24'd0);
        step();
        step();
        en = 2'b11;
        run_chk("m0", 0, 0, "0000", "1111");
        load(3'd0, 24'd1);
        run_chk("m1", 0, 0, "000", "111");
        en = 2'b10;
        run_chk("m1_off", 0, 0, "0", "0");

        // Both channels at 6, started out of phase, then realigned by sync.
        en = 2'b00;
        load(3'd0, 24'd6);
        step();
        load(3'd1, 24'd6);
        step();
        step();
        en = 2'b01;
        step();
        step();
        en = 2'b11;
        repeat (4) step();
        sync = 1'b1;
        step();
        check_eq("sync_clk_out", 32'(clk_out), 32'd0);
        check_eq("sync_tick", 32'(tick), 32'd0);
        load(3'd3, 24'd2);
        run_chk("sync6", 0, 1, "00111000111000111000", "00000100000100000100");

        // Asynchronous reset with the clock stopped while clk_out is high.
        step();
        check_eq("pre_rst_clk_out", 32'(clk_out), 32'd3);
        clk_run = 1'b0;
        #23;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_clk_out", 32'(clk_out), 32'd0);
        check_eq("async_rst_tick", 32'(tick), 32'd0);
        #10;
        clk_run = 1'b1;
        step();
        rst_n = 1'b1;
        run_chk("post_rst", 0, 1, "01100110", "00010001");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Multi-channel programmable clock divider. Each channel has a divisor that can be changed at runtime and a clock-enable. Each channel produces a near-50% divided clock and a one-cycle wrap tick. Divisor changes are shadowed so that they take effect only at a period boundary, which keeps the outputs glitch-free. The block sits next to the board oscillator and supplies all slow timebases: LED blink, note generation and UART baud strobes.

## Interface
Parameters:
- CHANNELS, 2: number of independent divider channels (1..8).
- WIDTH, 24: width of each divisor and counter.
- DEFAULT_DIV, 12_000_000: divisor loaded into every channel at reset. Must fit in WIDTH bits.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset. Asynchronous assert, active-low. Release is synchronous to clk_in externally.
- en  input  CHANNELS  per-channel run enable.
- sync  input  1  one-cycle pulse that restarts all channels in phase.
- div_load  input  1  write strobe for a divisor.
- div_ch  input  3  target channel index for div_load.
- div_val  input  WIDTH  new divisor value (M).
- clk_out  output  CHANNELS  divided clock per channel (registered).
- tick  output  CHANNELS  one-cycle pulse per channel period (registered).

## Operation
Per-channel state:
- shadow[WIDTH]: holds the most recently loaded divisor.
- act[WIDTH]: the divisor in use.
- cnt[WIDTH]: the period counter.
- out: the registered clk_out bit.
- tk: the registered tick bit.

Effective divisor: Meff = (act == 0) ? 1 : act. The high count is H = Meff >> 1 and the low count is L = Meff − H.

Divisor load:
- On div_load, when div_ch < CHANNELS: shadow[div_ch] <= div_val.
- When div_ch ≥ CHANNELS the write is ignored with no side effects.
- shadow is never read combinationally into the output path.

Per-channel update, evaluated each edge in priority order:
1. rst_n low (asynchronous): shadow = act = DEFAULT_DIV, cnt = 0, out = 0, tk = 0.
2. en low: cnt <= 0, out <= 0, tk <= 0, act <= shadow. Disable is a synchronous clear and picks up a pending divisor immediately.
3. sync high: same as step 2 (act <= shadow), applied to every enabled channel.
4. Wrap, when cnt == Meff−1: cnt <= 0, out <= 0, tk <= 1, act <= shadow.
5. Otherwise: cnt <= cnt+1 and tk <= 0. If cnt+1 == L, then out <= 1; otherwise out holds.

Resulting waveform:
- clk_out is low for L cycles and high for H cycles per period. Each period starts low.
- Even Meff gives exactly 50% duty. Odd Meff has the low phase one cycle longer.
- M = 0 or 1: clk_out stays constant 0 and tick is high every enabled cycle.

Load at the same edge as a wrap:
- The wrap copies the old shadow into act. The new value lands in shadow.
- The new value therefore takes effect at the following wrap. There is no bypass.

A load on a disabled channel takes effect on the first edge after the load, through the en-low path.

## Timing
- Reset outputs: clk_out = 0 and tick = 0 for all channels.
- First edge with en high after reset or disable: cnt goes 0 → 1.
- First rising edge of clk_out comes L edges after enable.
- First tick is high for one cycle starting Meff edges after enable.
- Period: exactly Meff clk_in cycles between consecutive tick pulses, for as long as en stays high and act is unchanged.
- Divisor change latency: the new period starts at the first wrap after the shadow write. There is never a truncated or stretched period other than the old one completing.
- sync: clears every enabled channel on the edge where it is sampled. Two channels with equal Meff then have identical clk_out and tick thereafter.
- rst_n asserted mid-period: outputs go to 0 immediately, without waiting for clk_in.
- Outputs come straight from flops, with no combinational path from any input to clk_out or tick.

## Test plan
- Reset, DEFAULT_DIV overridden to 4 for simulation, en = 2'b11 → clk_out = 0,0,1,1 repeating per channel. tick is high 1 cycle every 4. The first tick is 4 edges after enable.
- Load M = 5 on ch0 while running at 4 → the current 4-period completes. Then the pattern is low 3, high 2. Tick spacing changes from 4 to 5 with no short period.
- Load M = 7 on the exact edge where ch1 wraps → the next period is still 4. The period after that is 7 (low 4, high 3).
- M = 0 and M = 1 on ch0 → clk_out stays 0 and tick stays 1 on every enabled cycle. Dropping en gives tick 0 on the next edge.
- Ch0 M = 6 and ch1 M = 6 running out of phase. Pulse sync for 1 cycle → both restart together, and clk_out[0] == clk_out[1] and tick[0] == tick[1] for 20 cycles. A load with div_ch = 3 while CHANNELS = 2 causes no change.
- Assert rst_n low mid-period with clk_in stopped → clk_out and tick go to 0 asynchronously. After release, divisors are back to DEFAULT_DIV.
